// File: rtl/pipe_skid_stage_pkg.sv
// Shared types for the pipeline stage registers: occupancy state encoding,
// default payload geometry and the per-stage payload structs.
package pipe_pkg;

  localparam int unsigned PIPE_DATA_W     = 32;
  localparam int unsigned PIPE_NUM_FIELDS = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  // Field 0 sits at the LSBs of in_data/out_data, so it is the last member.
  typedef struct packed {
    logic [PIPE_DATA_W-1:0] pc;
    logic [PIPE_DATA_W-1:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [PIPE_DATA_W-1:0] pc;
    logic [PIPE_DATA_W-1:0] rs1_val;
    logic [PIPE_DATA_W-1:0] rs2_val;
    logic [PIPE_DATA_W-1:0] imm;
  } id_ex_t;

  typedef struct packed {
    logic [PIPE_DATA_W-1:0] pc;
    logic [PIPE_DATA_W-1:0] alu_out;
    logic [PIPE_DATA_W-1:0] store_data;
    logic [PIPE_DATA_W-1:0] cmp_out;
  } ex_mem_t;

  typedef struct packed {
    logic [PIPE_DATA_W-1:0] pc;
    logic [PIPE_DATA_W-1:0] rdata;
    logic [PIPE_DATA_W-1:0] alu_out;
    logic [PIPE_DATA_W-1:0] cmp_out;
  } mem_wb_t;

  function automatic logic [1:0] occ_of(input pipe_state_e s);
    return s;
  endfunction

endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Generic valid/ready pipeline stage register: 2-entry skid buffer with a
// registered in_ready (SKID=1) or a single register (SKID=0), plus flush.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = PIPE_DATA_W,
  parameter int unsigned NUM_FIELDS = PIPE_NUM_FIELDS,
  parameter bit          SKID       = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_FIELDS*DATA_W-1:0] out_data,
  output logic [1:0]                   occupancy,
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam int unsigned PAYLOAD_W = NUM_FIELDS * DATA_W;

  logic stall;
  assign stall = out_valid && !out_ready;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (stall),
    .count (stall_cnt)
  );

  if (SKID) begin : g_skid
    pipe_state_e          state_q, state_d;
    logic [PAYLOAD_W-1:0] main_q, main_d;
    logic [PAYLOAD_W-1:0] skid_q, skid_d;
    logic                 in_ready_q, in_ready_d;
    logic                 accept;
    logic                 consume;

    assign accept  = in_valid && in_ready_q;
    assign consume = (state_q != EMPTY) && out_ready;

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
      // Flush wins over every transition; payload registers simply keep their contents.
      if (flush) begin
        state_d = EMPTY;
        main_d  = main_q;
        skid_d  = skid_q;
      end
      in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q    <= EMPTY;
        main_q     <= '0;
        skid_q     <= '0;
        in_ready_q <= 1'b1;
      end else begin
        state_q    <= state_d;
        main_q     <= main_d;
        skid_q     <= skid_d;
        in_ready_q <= in_ready_d;
      end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = occ_of(state_q);

  end else begin : g_single
    logic                 valid_q, valid_d;
    logic [PAYLOAD_W-1:0] data_q, data_d;
    logic                 ready_c;

    assign ready_c = !valid_q || out_ready;

    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush) begin
        valid_d = 1'b0;
      end else if (in_valid && ready_c) begin
        valid_d = 1'b1;
        data_d  = in_data;
      end else if (valid_q && out_ready) begin
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end

    assign in_ready  = ready_c;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign occupancy = {1'b0, valid_q};
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: skid, single-register and 4-bit counter variants share stimulus.
module tb_pipe_skid_stage;
  import pipe_pkg::*;

  logic         clk;
  logic         reset_n;
  logic         flush;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] in_data;

  logic         s_in_ready, s_out_valid;
  logic [127:0] s_out_data;
  logic [1:0]   s_occ;
  logic [15:0]  s_stall;

  logic         z_in_ready, z_out_valid;
  logic [127:0] z_out_data;
  logic [1:0]   z_occ;
  logic [15:0]  z_stall;

  logic         c_in_ready, c_out_valid;
  logic [127:0] c_out_data;
  logic [1:0]   c_occ;
  logic [3:0]   c_stall;

  int total;
  int bad;

  mem_wb_t pkt;

  pipe_skid_stage #(.DATA_W(32), .NUM_FIELDS(4), .SKID(1'b1), .CNT_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .occupancy(s_occ), .stall_cnt(s_stall));

  pipe_skid_stage #(.DATA_W(32), .NUM_FIELDS(4), .SKID(1'b0), .CNT_W(16)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(z_in_ready),
    .in_data(in_data), .out_valid(z_out_valid), .out_ready(out_ready), .out_data(z_out_data),
    .occupancy(z_occ), .stall_cnt(z_stall));

  pipe_skid_stage #(.DATA_W(32), .NUM_FIELDS(4), .SKID(1'b1), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
    .occupancy(c_occ), .stall_cnt(c_stall));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset values
    do_reset();
    chk("rst_out_valid", s_out_valid, 1'b0);
    chk("rst_in_ready", s_in_ready, 1'b1);
    chk("rst_occ", s_occ, 2'd0);
    chk("rst_stall", s_stall, 16'd0);
    chk("rst_out_data", s_out_data, 128'd0);
    chk("rst0_in_ready", z_in_ready, 1'b1);
    chk("rst0_out_valid", z_out_valid, 1'b0);

    // Single transfer with mem_wb_t payload
    pkt.pc = 32'h60; pkt.rdata = 32'hDEADBEEF; pkt.alu_out = 32'h1234; pkt.cmp_out = 32'h1;
    in_data   = pkt;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("xfer_out_valid", s_out_valid, 1'b1);
    chk("xfer_out_data", s_out_data, 128'h00000060_DEADBEEF_00001234_00000001);
    chk("xfer_occ1", s_occ, 2'd1);
    chk("xfer0_out_data", z_out_data, 128'h00000060_DEADBEEF_00001234_00000001);
    step();
    chk("xfer_occ0", s_occ, 2'd0);
    chk("xfer_drain_valid", s_out_valid, 1'b0);
    chk("xfer_stall", s_stall, 16'd0);

    // Back-pressure fill
    do_reset();
    in_valid = 1'b1;
    in_data  = 128'h11;
    step();
    chk("bp_occ1", s_occ, 2'd1);
    chk("bp_ready1", s_in_ready, 1'b1);
    chk("bp_stall0", s_stall, 16'd0);
    in_data = 128'h22;
    step();
    in_valid = 1'b0;
    chk("bp_occ2", s_occ, 2'd2);
    chk("bp_ready_full", s_in_ready, 1'b0);
    chk("bp_head_a", s_out_data, 128'h11);
    chk("bp_stall1", s_stall, 16'd1);
    chk("bp0_ready_comb_lo", z_in_ready, 1'b0);
    step();
    chk("bp_stall2", s_stall, 16'd2);
    out_ready = 1'b1;
    #1;
    chk("bp0_ready_comb_hi", z_in_ready, 1'b1);
    chk("bp_ready_registered", s_in_ready, 1'b0);
    step();
    chk("bp_head_b", s_out_data, 128'h22);
    chk("bp_occ_after1", s_occ, 2'd1);
    chk("bp_ready_back", s_in_ready, 1'b1);
    chk("bp_stall_hold", s_stall, 16'd2);
    step();
    chk("bp_empty", s_out_valid, 1'b0);
    chk("bp_occ_end", s_occ, 2'd0);

    // Full throughput, both variants
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 128'(i);
      step();
      chk("tp_data", s_out_data, 128'(i));
      chk("tp_valid", s_out_valid, 1'b1);
      chk("tp_occ", s_occ, 2'd1);
      chk("tp0_data", z_out_data, 128'(i));
      chk("tp0_valid", z_out_valid, 1'b1);
    end
    in_valid = 1'b0;
    step();
    chk("tp_stall", s_stall, 16'd0);
    chk("tp0_stall", z_stall, 16'd0);
    chk("tp_drained", s_occ, 2'd0);

    // Flush while FULL drops concurrent input
    do_reset();
    in_valid = 1'b1;
    in_data  = 128'h11;
    step();
    in_data = 128'h22;
    step();
    chk("fl_full", s_occ, 2'd2);
    in_data = 128'h33;
    flush   = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", s_out_valid, 1'b0);
    chk("fl_occ", s_occ, 2'd0);
    chk("fl_in_ready", s_in_ready, 1'b1);
    chk("fl_stall", s_stall, 16'd2);
    out_ready = 1'b1;
    step();
    chk("fl_no_33", s_out_valid, 1'b0);
    step();
    chk("fl_no_33_b", s_out_valid, 1'b0);
    chk("fl_stall_kept", s_stall, 16'd2);

    // Stall counter saturation (4-bit instance)
    do_reset();
    in_valid = 1'b1;
    in_data  = 128'h44;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("sat_c10", c_stall, 4'd10);
    for (int i = 0; i < 5; i++) step();
    chk("sat_c15", c_stall, 4'd15);
    for (int i = 0; i < 5; i++) step();
    chk("sat_hold", c_stall, 4'd15);
    chk("sat_wide20", s_stall, 16'd20);
    chk("sat_occ", c_occ, 2'd1);

    // Asynchronous reset mid-stream
    do_reset();
    in_valid = 1'b1;
    in_data  = 128'h55;
    step();
    in_data = 128'h66;
    step();
    step();
    in_valid = 1'b0;
    chk("ar_full", s_occ, 2'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_out_valid", s_out_valid, 1'b0);
    chk("ar_in_ready", s_in_ready, 1'b1);
    chk("ar_occ", s_occ, 2'd0);
    chk("ar_stall", s_stall, 16'd0);
    chk("ar_out_data", s_out_data, 128'd0);
    step();
    reset_n = 1'b1;
    step();
    chk("ar_post", s_out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised pipeline stage register that succeeds the fixed-field MEM->WB register. It carries NUM_FIELDS words of DATA_W bits plus a valid bit under a valid/ready handshake.
- When SKID=1, a 2-entry skid buffer lets in_ready be fully registered. This breaks the ready path between pipeline stages.
- Adds a synchronous flush (branch or exception squash) and a saturating back-pressure counter for performance monitoring.
- Instantiated between IF/ID/EX/MEM/WB stages in place of the per-stage hand-written registers.

Parameters:
- DATA_W, 32, width of each field in bits.
- NUM_FIELDS, 4, number of DATA_W fields carried (e.g. alu_out, rdata, pc, cmp_out zero-extended).
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream has data.
- in_ready  output  1  stage can accept data this cycle.
- in_data  input  NUM_FIELDS*DATA_W  packed fields, field 0 at LSBs.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  NUM_FIELDS*DATA_W  head entry.
- occupancy  output  2  entries held: 0..2 (SKID=0: 0..1).
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0; saturates at all-ones.

Behaviour:
- Reset (reset_n=0, asynchronous): out_valid=0, in_ready=1, occupancy=0, stall_cnt=0, out_data=0, skid entry=0. First transfer is possible on the first rising edge after deassertion.
- Transfer rules: input accepted when in_valid&&in_ready at the edge; output consumed when out_valid&&out_ready at the edge. Latency in->out is 1 cycle when empty.
- SKID=1 state machine (state equals occupancy):
  - EMPTY: accept -> ONE; main <= in_data.
  - ONE: accept && consume -> ONE, main <= in_data. Accept only -> FULL, skid <= in_data. Consume only -> EMPTY.
  - FULL: in_ready=0. Consume -> ONE, main <= skid.
  - in_ready is a flop: 1 exactly when next state != FULL. There is no combinational path from out_ready to in_ready.
- SKID=0:
  - Single register; in_ready = !out_valid || out_ready (combinational).
  - Simultaneous accept and consume reloads the register, giving full throughput.
- Ordering: strictly FIFO. The skid entry is never presented before main.
- Flush:
  - Flush at an edge empties the stage: occupancy=0, out_valid=0, in_ready=1 next cycle.
  - An input presented in the same cycle is dropped, even if in_valid&&in_ready.
  - A concurrent consume still counts as completed downstream.
  - Flush has priority over every transition.
  - Data registers need not be cleared on flush.
- out_data when out_valid=0: holds last value; not required to be zero.
- stall_cnt: increments by 1 at each edge where out_valid&&!out_ready. Holds at 2^CNT_W-1. Cleared only by reset; flush does not clear it.
- Reset mid-operation: all held entries are lost immediately (asynchronous). Outputs return to reset values without waiting for clk.
- in_data changing while in_valid=0 has no effect.

Decomposition:
- Shared package pipe_pkg:
  - typedef pipe_state_e {EMPTY=2'd0, ONE=2'd1, FULL=2'd2}.
  - Default DATA_W/NUM_FIELDS constants.
  - Packed struct typedefs for each stage payload (mem_wb_t with cmp_out, alu_out, rdata, pc), which callers cast to and from in_data/out_data.
- One natural sub-module: sat_counter, a parametrised width saturating incrementer with async active-low clear, used for stall_cnt.

Test Plan:
- Reset then single transfer: NUM_FIELDS=4, in_data={pc=0x60, rdata=0xDEADBEEF, alu=0x1234, cmp=1}, out_ready=1 -> out_valid=1 with identical data one cycle later; occupancy 1 then 0.
- Back-pressure fill (SKID=1): out_ready=0, push A=0x11 then B=0x22 -> occupancy=2, in_ready=0 on the next cycle, stall_cnt increments each stalled cycle. Release out_ready -> A then B in order; in_ready returns to 1 after the first consume.
- Full throughput: out_ready=1, in_valid=1 for 8 cycles with incrementing data 0..7 -> 8 consecutive outputs 0..7, occupancy stays 1, stall_cnt=0; repeat with SKID=0 for the same result.
- Flush while FULL: occupancy=2 and in_valid=1 with 0x33 at the flush edge -> next cycle out_valid=0, occupancy=0, in_ready=1. 0x33 is never output and stall_cnt is unchanged.
- Stall counter saturation: CNT_W=4, out_ready=0 with one entry held for 20 cycles -> stall_cnt reaches 15 and holds.
- Async reset mid-stream: pull reset_n low between clock edges while FULL -> out_valid=0, in_ready=1, occupancy=0, stall_cnt=0 immediately, before the next clk edge.
